// File: rtl/mmio_uart_tx.sv
// ----------------------------------------------------------------------------
// mmio_uart_tx : memory-mapped 8N1 UART transmitter with a TX byte FIFO. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module mmio_uart_tx #(
   parameter logic [31:0] BASE_ADDR            = 32'hFFFF_0000,
   parameter int          FIFO_DEPTH           = 8,
   parameter int          CLKS_PER_BIT_DEFAULT = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] address,
   input  logic [31:0] write_data,
   input  logic [3:0]  byte_enable,
   input  logic        we,
   output logic [31:0] read_data,
   output logic        sel,
   output logic        tx,
   output logic        tx_busy
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_START = 2'd1;
   localparam logic [1:0] S_DATA  = 2'd2;
   localparam logic [1:0] S_STOP  = 2'd3;

   logic [1:0]    state;
   logic [1:0]    state_next;
   logic          pop;
   logic          tx_next;

   logic [7:0]    fifo_mem [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic          overflow;
   logic [15:0]   divisor;

   logic [15:0]   bit_timer;
   logic [15:0]   div_eff;
   logic [15:0]   new_div;
   logic [2:0]    bit_cnt;
   logic [7:0]    shift;

   logic [1:0]    reg_idx;
   logic          wr_en;
   logic          push_req;
   logic          push_ok;
   logic          fifo_empty;
   logic          fifo_full;
   logic          timer_done;
   logic          w1c_hit;
   logic          unused_bits;

   assign sel         = (address[31:4] == BASE_ADDR[31:4]);
   assign reg_idx     = address[3:2];
   assign wr_en       = we && sel;
   assign push_req    = wr_en && (reg_idx == 2'd0) && byte_enable[0];
   assign w1c_hit     = wr_en && (reg_idx == 2'd1) && byte_enable[0] && write_data[3];
   assign fifo_empty  = (count == '0);
   assign fifo_full   = (count == CW'(FIFO_DEPTH));
   // A pop at the same edge frees the slot a full-FIFO push needs.
   assign push_ok     = push_req && (!fifo_full || pop);
   assign timer_done  = (bit_timer == 16'd0);
   assign new_div     = (divisor == 16'd0) ? 16'd1 : divisor;
   assign unused_bits = ^{address[1:0], write_data[31:16], byte_enable[3:2]};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      pop        = 1'b0;
      case (state)
         S_IDLE: begin
            if (!fifo_empty) begin
               pop        = 1'b1;
               state_next = S_START;
            end
         end
         S_START: if (timer_done) state_next = S_DATA;
         S_DATA:  if (timer_done && (bit_cnt == 3'd7)) state_next = S_STOP;
         S_STOP: begin
            if (timer_done) begin
               if (!fifo_empty) begin
                  pop        = 1'b1;
                  state_next = S_START;
               end else begin
                  state_next = S_IDLE;
               end
            end
         end
         default: state_next = S_IDLE;
      endcase
   end

   always_comb begin
      tx_next = tx;
      tx_busy = (state != S_IDLE);
      case (state)
         S_IDLE:  tx_next = !pop;
         S_START: if (timer_done) tx_next = shift[0];
         S_DATA:  if (timer_done) tx_next = (bit_cnt == 3'd7) ? 1'b1 : shift[1];
         S_STOP:  if (timer_done) tx_next = !pop;
         default: tx_next = 1'b1;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tx        <= 1'b1;
         bit_timer <= 16'd0;
         div_eff   <= 16'd1;
         bit_cnt   <= 3'd0;
         shift     <= 8'd0;
      end else begin
         tx <= tx_next;
         if (pop) begin
            // Divisor is sampled once per frame so mid-frame writes wait.
            shift     <= fifo_mem[rd_ptr];
            div_eff   <= new_div;
            bit_timer <= new_div - 16'd1;
            bit_cnt   <= 3'd0;
         end else if (state != S_IDLE) begin
            if (timer_done) begin
               bit_timer <= div_eff - 16'd1;
               if (state == S_DATA) begin
                  shift   <= shift >> 1;
                  bit_cnt <= bit_cnt + 3'd1;
               end
            end else begin
               bit_timer <= bit_timer - 16'd1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) fifo_mem[wr_ptr] <= write_data[7:0];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
         divisor  <= 16'(CLKS_PER_BIT_DEFAULT);
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + PW'(1);
         if (pop)     rd_ptr <= rd_ptr + PW'(1);
         case ({push_ok, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
         // A dropped push wins over a simultaneous clear.
         if (push_req && !push_ok) overflow <= 1'b1;
         else if (w1c_hit)         overflow <= 1'b0;
         if (wr_en && (reg_idx == 2'd2)) begin
            if (byte_enable[0]) divisor[7:0]  <= write_data[7:0];
            if (byte_enable[1]) divisor[15:8] <= write_data[15:8];
         end
      end
   end

   always_comb begin
      read_data = 32'd0;
      if (sel) begin
         case (reg_idx)
            2'd1: begin
               read_data[0]      = fifo_full;
               read_data[1]      = fifo_empty;
               read_data[2]      = tx_busy;
               read_data[3]      = overflow;
               read_data[CW+7:8] = count;
            end
            2'd2:    read_data[15:0] = divisor;
            default: read_data = 32'd0;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_mmio_uart_tx.sv
// ----------------------------------------------------------------------------
// tb_mmio_uart_tx : self-checking bench for mmio_uart_tx. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_mmio_uart_tx;

   localparam logic [31:0] BASE = 32'hFFFF_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] address;
   logic [31:0] write_data;
   logic [3:0]  byte_enable;
   logic        we;
   logic [31:0] read_data;
   logic        sel;
   logic        tx;
   logic        tx_busy;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   logic [7:0] fq[$];
   int         dq[$];
   logic [7:0] bytes [12];
   int         n;
   int         d_raw;
   int         d_eff;
   int         kc;
   int         stored;
   int         ovf;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   mmio_uart_tx dut (
      .clk         (clk),
      .rst         (rst),
      .address     (address),
      .write_data  (write_data),
      .byte_enable (byte_enable),
      .we          (we),
      .read_data   (read_data),
      .sel         (sel),
      .tx          (tx),
      .tx_busy     (tx_busy)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [3:0] off, input logic [31:0] data, input logic [3:0] be);
      address     = BASE | {28'd0, off};
      write_data  = data;
      byte_enable = be;
      we          = 1'b1;
      @(posedge clk);
      #1;
      we          = 1'b0;
      byte_enable = 4'd0;
   endtask

   task automatic rd(input string tag, input logic [3:0] off, input logic [31:0] exp);
      address = BASE | {28'd0, off};
      we      = 1'b0;
      #1;
      check(tag, read_data, exp);
   endtask

   function automatic logic [31:0] status(input int cnt, input int ov, input int busy);
      return (cnt << 8) | (ov << 3) | (busy << 2) | ((cnt == 0) ? 2 : 0) | ((cnt == 8) ? 1 : 0);
   endfunction

   // 8N1 frame: bit 0 start, bits 1..8 data LSB first, bit 9 stop.
   function automatic logic exp_bit(input logic [7:0] b, input int i);
      if (i == 0) return 1'b0;
      if (i == 9) return 1'b1;
      return b[i-1];
   endfunction

   // Starts right after the edge that pushed the first queued byte.
   task automatic watch();
      logic [7:0] b;
      int d;
      while (fq.size() > 0) begin
         b = fq.pop_front();
         d = dq.pop_front();
         for (int c = 0; c < 10 * d; c++) begin
            @(posedge clk);
            #1;
            check("tx_bit", tx, exp_bit(b, c / d));
            check("tx_busy_frame", tx_busy, 1);
         end
      end
      @(posedge clk);
      #1;
      check("tx_idle", tx, 1);
      check("busy_idle", tx_busy, 0);
   endtask

   initial begin
      rst = 1'b1; we = 1'b0; address = 32'd0; write_data = 32'd0; byte_enable = 4'd0;
      repeat (3) @(posedge clk);
      @(negedge clk) rst = 1'b0;
      @(posedge clk);
      #1;

      check("reset_tx", tx, 1);
      check("reset_busy", tx_busy, 0);
      rd("reset_status", 4'h4, 32'h2);
      rd("reset_div", 4'h8, 32'd16);
      rd("txdata_reads_0", 4'h0, 32'd0);
      check("sel_hit", sel, 1);
      address = 32'h1000_0004;
      #1;
      check("sel_miss", sel, 0);
      check("rdata_miss", read_data, 0);

      wr(4'h8, 32'hFFFF_ABCD, 4'b0010);
      rd("div_byte_en", 4'h8, 32'h0000_AB10);
      wr(4'hC, 32'hFFFF_FFFF, 4'hF);
      rd("reserved_rd", 4'hC, 32'd0);
      wr(4'h0, 32'h77, 4'b1110);
      @(posedge clk);
      #1;
      check("no_push_be", tx_busy, 0);
      rd("no_push_status", 4'h4, 32'h2);
      address = 32'h0000_0000; write_data = 32'h55; byte_enable = 4'h1; we = 1'b1;
      @(posedge clk);
      #1;
      we = 1'b0;
      @(posedge clk);
      #1;
      check("unsel_write_tx", tx, 1);
      rd("unsel_write_status", 4'h4, 32'h2);

      // Single frame, divisor 4
      wr(4'h8, 32'd4, 4'b0011);
      fq.push_back(8'h55); dq.push_back(4);
      wr(4'h0, 32'h55, 4'h1);
      watch();

      // Two back-to-back frames with no idle gap
      wr(4'h8, 32'd4, 4'b0011);
      fq.push_back(8'hA5); dq.push_back(4);
      fq.push_back(8'h3C); dq.push_back(4);
      wr(4'h0, 32'hA5, 4'h1);
      fork
         wr(4'h0, 32'h3C, 4'h1);
         watch();
      join

      // Random divisors (0 acts as 1) and random byte streams
      for (int it = 0; it < 4; it++) begin
         d_raw = (it == 0) ? 0 : int'($urandom_range(0, 5));
         d_eff = (d_raw == 0) ? 1 : d_raw;
         n     = int'($urandom_range(1, 3));
         for (int i = 0; i < n; i++) begin
            bytes[i] = 8'($urandom);
            fq.push_back(bytes[i]);
            dq.push_back(d_eff);
         end
         wr(4'h8, d_raw, 4'b0011);
         rd("div_readback", 4'h8, d_raw);
         wr(4'h0, {24'd0, bytes[0]}, 4'h1);
         fork
            begin
               for (int i = 1; i < n; i++) wr(4'h0, {24'd0, bytes[i]}, 4'h1);
            end
            watch();
         join
      end

      // Divisor change mid-frame applies to the next frame only
      wr(4'h8, 32'd4, 4'b0011);
      bytes[0] = 8'($urandom);
      fq.push_back(8'hFF); dq.push_back(4);
      fq.push_back(bytes[0]); dq.push_back(2);
      wr(4'h0, 32'hFF, 4'h1);
      fork
         begin
            repeat (9) @(posedge clk);
            #1;
            wr(4'h8, 32'd2, 4'b0011);
            wr(4'h0, {24'd0, bytes[0]}, 4'h1);
         end
         watch();
      join
      rd("div_after_change", 4'h8, 32'd2);

      // Overflow: slow divisor, burst of n bytes, first one popped
      wr(4'h8, 32'd1000, 4'b0011);
      n = int'($urandom_range(9, 12));
      for (int i = 0; i < n; i++) bytes[i] = 8'($urandom);
      bytes[0][0] = 1'b0;
      wr(4'h0, {24'd0, bytes[0]}, 4'h1);
      kc = cyc;
      for (int i = 1; i < n; i++) wr(4'h0, {24'd0, bytes[i]}, 4'h1);
      stored = (n - 1 > 8) ? 8 : n - 1;
      ovf    = (n - 1 > 8) ? 1 : 0;
      rd("burst_status", 4'h4, status(stored, ovf, 1));
      wr(4'h0, 32'hEE, 4'h1);
      rd("push_full_status", 4'h4, status(8, 1, 1));
      wr(4'h4, 32'h0, 4'h1);
      rd("w1c_zero_keeps", 4'h4, status(8, 1, 1));
      wr(4'h4, 32'h8, 4'b1110);
      rd("w1c_no_be_keeps", 4'h4, status(8, 1, 1));
      wr(4'h4, 32'h8, 4'h1);
      rd("w1c_clears", 4'h4, status(8, 0, 1));

      // Async reset in the middle of data bit 0 (a zero bit)
      while (cyc < kc + 1500) begin
         @(posedge clk);
         #1;
      end
      #2;
      check("pre_reset_tx", tx, 0);
      check("pre_reset_busy", tx_busy, 1);
      rst = 1'b1;
      #1;
      check("async_reset_tx", tx, 1);
      check("async_reset_busy", tx_busy, 0);
      rd("async_reset_status", 4'h4, 32'h2);
      @(posedge clk);
      @(negedge clk) rst = 1'b0;
      @(posedge clk);
      #1;
      rd("post_reset_status", 4'h4, 32'h2);
      rd("post_reset_div", 4'h8, 32'd16);
      repeat (20) @(posedge clk);
      #1;
      check("no_resume_tx", tx, 1);
      check("no_resume_busy", tx_busy, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
